approx_mult_pipe: RTL

- Parametrised, pipelined unsigned approximate multiplier; successor to the fixed 8x8 row-truncating multipliers.
- Drops the low L partial-product rows. Each dropped row is compensated by keeping only its top KEEP bits.
- A runtime mode input selects exact or approximate output. Valid/ready handshake on input and output.
- Built-in error monitor (mismatch count, max error) for on-silicon accuracy characterisation inside the multiplier-evaluation harness.

---
 rtl/approx_mult_pkg.sv | 37 +++
 rtl/approx_mult_pp_gen.sv | 34 +++
 rtl/approx_mult_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared constants and reference arithmetic for the approximate multiplier.
// approx_ref is the bit-level row model used by the bench scoreboard.
package approx_mult_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;
    localparam int   MAX_W       = 32;

    // Ones in bit positions [w-1 : w-keep], zero elsewhere.
    function automatic logic [MAX_W-1:0] keep_mask(input int w, input int keep);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b >= w - keep && b < w) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2*MAX_W-1:0] approx_ref(
        input int               w,
        input int               l,
        input int               keep,
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y
    );
        logic [2*MAX_W-1:0] acc;
        logic [MAX_W-1:0]   row;
        acc = '0;
        for (int i = 0; i < w; i++) begin
            row = x[i] ? y : '0;
            if (i < l) row = row & keep_mask(w, keep);
            acc = acc + ({{MAX_W{1'b0}}, row} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/approx_mult_pp_gen.sv
// Combinational partial-product generator: upper rows as one multiply,
// low rows reduced to their top KEEP bits, plus the exact product.
module approx_pp_gen
    import approx_mult_pkg::*;
#(
    parameter int W    = 8,
    parameter int L    = 2,
    parameter int KEEP = 1
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] kept,
    output logic [2*W-1:0] comp,
    output logic [2*W-1:0] prod
);

    localparam int PW = 2 * W;

    logic [PW-1:0] csum [L+1];

    assign prod = PW'(x) * PW'(y);
    assign kept = (PW'(y) * PW'(x >> L)) << L;

    assign csum[0] = '0;
    for (genvar i = 0; i < L; i++) begin : g_row
        localparam logic [W-1:0] MASK = W'(keep_mask(W, KEEP));
        logic [W-1:0] row;
        assign row       = y & {W{x[i]}} & MASK;
        assign csum[i+1] = csum[i] + (PW'(row) << i);
    end

    assign comp = csum[L];

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined approximate/exact multiplier with global-stall handshake and
// an error monitor over delivered approximate results.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W      = 8,
    parameter int L      = 2,
    parameter int KEEP   = 1,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic             z_exact,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2*W-1:0]   err_max
);

    localparam int PW = 2 * W;

    logic              en;
    logic [STAGES:1]   vld_pipe;
    logic [STAGES:1]   mode_pipe;
    logic [W-1:0]      pp_x, pp_y;
    logic [PW-1:0]     pp_kept, pp_comp, pp_prod;
    logic [PW-1:0]     fin_kept, fin_comp, fin_prod;
    logic              fin_mode;
    logic [PW-1:0]     fin_approx;
    logic [PW-1:0]     err_q;
    logic              stat_hs;

    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign z_exact   = mode_pipe[STAGES];

    // Bubbles shift like real beats so every slot keeps its position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            mode_pipe <= '0;
        end else if (en) begin
            vld_pipe[1]  <= in_valid;
            mode_pipe[1] <= exact;
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                mode_pipe[k] <= mode_pipe[k-1];
            end
        end
    end

    approx_pp_gen #(
        .W    (W),
        .L    (L),
        .KEEP (KEEP)
    ) u_pp (
        .x    (pp_x),
        .y    (pp_y),
        .kept (pp_kept),
        .comp (pp_comp),
        .prod (pp_prod)
    );

    if (STAGES == 1) begin : g_comb
        assign pp_x     = x;
        assign pp_y     = y;
        assign fin_kept = pp_kept;
        assign fin_comp = pp_comp;
        assign fin_prod = pp_prod;
        assign fin_mode = exact;
    end else begin : g_piped
        logic [W-1:0] x_q, y_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                x_q <= '0;
                y_q <= '0;
            end else if (en) begin
                x_q <= x;
                y_q <= y;
            end
        end

        assign pp_x     = x_q;
        assign pp_y     = y_q;
        assign fin_mode = mode_pipe[STAGES-1];

        if (STAGES == 2) begin : g_direct
            assign fin_kept = pp_kept;
            assign fin_comp = pp_comp;
            assign fin_prod = pp_prod;
        end else begin : g_part
            // Partials enter at stage 2 and ride along until the output stage.
            logic [PW-1:0] kept_q [2:STAGES-1];
            logic [PW-1:0] comp_q [2:STAGES-1];
            logic [PW-1:0] prod_q [2:STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 2; k <= STAGES - 1; k++) begin
                        kept_q[k] <= '0;
                        comp_q[k] <= '0;
                        prod_q[k] <= '0;
                    end
                end else if (en) begin
                    kept_q[2] <= pp_kept;
                    comp_q[2] <= pp_comp;
                    prod_q[2] <= pp_prod;
                    for (int k = 3; k <= STAGES - 1; k++) begin
                        kept_q[k] <= kept_q[k-1];
                        comp_q[k] <= comp_q[k-1];
                        prod_q[k] <= prod_q[k-1];
                    end
                end
            end

            assign fin_kept = kept_q[STAGES-1];
            assign fin_comp = comp_q[STAGES-1];
            assign fin_prod = prod_q[STAGES-1];
        end
    end

    assign fin_approx = fin_kept + fin_comp;

    // Approx never exceeds the exact product, so the difference cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z     <= '0;
            err_q <= '0;
        end else if (en) begin
            z     <= (fin_mode == MODE_EXACT) ? fin_prod : fin_approx;
            err_q <= fin_prod - fin_approx;
        end
    end

    assign stat_hs = out_valid & out_ready & (z_exact == MODE_APPROX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stat_hs) begin
            if (err_q != '0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (err_q > err_max) err_max <= err_q;
        end
    end

endmodule
